// File: rtl/asrv32_decode_queue.sv
// asrv32_decode_queue
//   Buffered, handshaked RV32 decode stage. Fetched {pc, inst} pairs are
//   written into a DEPTH-entry FIFO. The FIFO head is decoded
//   combinationally, and the result is registered into a single output slot.
//   This lets fetch stalls and execute stalls decouple from each other.
//
//   Optional feature: define ASRV32_DECODE_MEXT_EN to decode the RV32M
//   multiply/divide group (RTYPE, funct7=0000001) into o_mext_op.
//   When the macro is not defined, o_mext_op stays 0 and that encoding is
//   illegal.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_inst_valid/o_inst_ready/i_inst/i_pc
//                         fetch-side handshake and payload
//   i_flush               drop everything queued plus the output slot
//   o_valid/i_ready       execute-side handshake for the output slot
//   o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm, o_funct3
//                         decoded fields
//   o_opcode, o_alu_op, o_mext_op
//                         one-hot class, ALU and M-extension selects
//   o_illegal             slot holds an illegal encoding
//   o_count               FIFO occupancy (the output slot is not counted)

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif

// o_opcode bit positions
`ifndef RTYPE
`define RTYPE 0
`endif
`ifndef ITYPE
`define ITYPE 1
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif
`ifndef BRANCH
`define BRANCH 4
`endif
`ifndef JAL
`define JAL 5
`endif
`ifndef JALR
`define JALR 6
`endif
`ifndef LUI
`define LUI 7
`endif
`ifndef AUIPC
`define AUIPC 8
`endif
`ifndef SYSTEM
`define SYSTEM 9
`endif
`ifndef FENCE
`define FENCE 10
`endif

// o_alu_op bit positions
`ifndef ADD
`define ADD 0
`endif
`ifndef SUB
`define SUB 1
`endif
`ifndef SLT
`define SLT 2
`endif
`ifndef SLTU
`define SLTU 3
`endif
`ifndef XOR
`define XOR 4
`endif
`ifndef OR
`define OR 5
`endif
`ifndef AND
`define AND 6
`endif
`ifndef SLL
`define SLL 7
`endif
`ifndef SRL
`define SRL 8
`endif
`ifndef SRA
`define SRA 9
`endif
`ifndef EQ
`define EQ 10
`endif
`ifndef NEQ
`define NEQ 11
`endif
`ifndef GE
`define GE 12
`endif
`ifndef GEU
`define GEU 13
`endif

module asrv32_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_inst_valid,
  output logic                      o_inst_ready,
  input  logic [31:0]               i_inst,
  input  logic [PC_WIDTH-1:0]       i_pc,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [PC_WIDTH-1:0]       o_pc,
  output logic [4:0]                o_rs1_addr,
  output logic [4:0]                o_rs2_addr,
  output logic [4:0]                o_rd_addr,
  output logic [31:0]               o_imm,
  output logic [2:0]                o_funct3,
  output logic [`OPCODE_WIDTH-1:0]  o_opcode,
  output logic [`ALU_WIDTH-1:0]     o_alu_op,
  output logic [7:0]                o_mext_op,
  output logic                      o_illegal,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // FIFO storage and control
  logic [PC_WIDTH-1:0]      r_mem_pc   [DEPTH];
  logic [31:0]              r_mem_inst [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  // Output slot
  logic                     r_valid;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [4:0]               r_rs1;
  logic [4:0]               r_rs2;
  logic [4:0]               r_rd;
  logic [31:0]              r_imm;
  logic [2:0]               r_funct3;
  logic [`OPCODE_WIDTH-1:0] r_opcode;
  logic [`ALU_WIDTH-1:0]    r_alu;
  logic [7:0]               r_mext;
  logic                     r_illegal;

  logic                     w_push;
  logic                     w_pop;
  logic [PC_WIDTH-1:0]      w_head_pc;
  logic [31:0]              w_inst;
  logic [6:0]               w_op;
  logic [2:0]               w_f3;
  logic [6:0]               w_f7;

  logic [31:0]              w_imm_i;
  logic [31:0]              w_imm_s;
  logic [31:0]              w_imm_b;
  logic [31:0]              w_imm_j;
  logic [31:0]              w_imm_u;
  logic [31:0]              w_imm_z;

  logic [`ALU_WIDTH-1:0]    w_arith_alu;
  logic [`ALU_WIDTH-1:0]    w_branch_alu;
  logic [`OPCODE_WIDTH-1:0] w_opc;
  logic [`ALU_WIDTH-1:0]    w_alu;
  logic [7:0]               w_mext;
  logic [31:0]              w_imm;
  logic                     w_bad;

  // Ready deliberately ignores i_ready: only occupancy and reset gate intake.
  assign o_inst_ready = (r_count < CW'(DEPTH)) & i_rst_n;
  assign w_push       = i_inst_valid & o_inst_ready & ~i_flush;
  assign w_pop        = (r_count != '0) & (~r_valid | i_ready) & ~i_flush;

  assign w_head_pc = r_mem_pc[r_rd_ptr];
  assign w_inst    = r_mem_inst[r_rd_ptr];
  assign w_op      = w_inst[6:0];
  assign w_f3      = w_inst[14:12];
  assign w_f7      = w_inst[31:25];

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                    w_inst[11:8], 1'b0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                    w_inst[30:21], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_z = {20'b0, w_inst[31:20]};

  // Arithmetic op from funct3. inst[30] selects SUB only for register-register
  // ADD (ADDI has no SUB form), and selects SRA for both shift-right forms.
  always_comb begin
    w_arith_alu = '0;
    case (w_f3)
      3'b000: begin
        if ((w_op == OPC_RTYPE) && w_inst[30]) w_arith_alu[`SUB] = 1'b1;
        else                                   w_arith_alu[`ADD] = 1'b1;
      end
      3'b001: w_arith_alu[`SLL]  = 1'b1;
      3'b010: w_arith_alu[`SLT]  = 1'b1;
      3'b011: w_arith_alu[`SLTU] = 1'b1;
      3'b100: w_arith_alu[`XOR]  = 1'b1;
      3'b101: begin
        if (w_inst[30]) w_arith_alu[`SRA] = 1'b1;
        else            w_arith_alu[`SRL] = 1'b1;
      end
      3'b110: w_arith_alu[`OR]   = 1'b1;
      default: w_arith_alu[`AND] = 1'b1;
    endcase
  end

  // Branch comparison from funct3; 010/011 are reserved and flagged below.
  always_comb begin
    w_branch_alu = '0;
    case (w_f3)
      3'b000:  w_branch_alu[`EQ]   = 1'b1;
      3'b001:  w_branch_alu[`NEQ]  = 1'b1;
      3'b100:  w_branch_alu[`SLT]  = 1'b1;
      3'b101:  w_branch_alu[`GE]   = 1'b1;
      3'b110:  w_branch_alu[`SLTU] = 1'b1;
      3'b111:  w_branch_alu[`GEU]  = 1'b1;
      default: w_branch_alu = '0;
    endcase
  end

  // Class, immediate and legality of the FIFO head. The immediate depends
  // only on the major opcode, so an illegal funct field still carries it.
  always_comb begin
    w_opc  = '0;
    w_alu  = '0;
    w_mext = '0;
    w_imm  = '0;
    w_bad  = 1'b0;
    case (w_op)
      OPC_RTYPE: begin
        w_opc[`RTYPE] = 1'b1;
        if ((w_f7 == 7'b0000000) ||
            ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))))
          w_alu = w_arith_alu;
`ifdef ASRV32_DECODE_MEXT_EN
        else if (w_f7 == 7'b0000001)
          w_mext[w_f3] = 1'b1;
`endif
        else
          w_bad = 1'b1;
      end
      OPC_ITYPE: begin
        w_opc[`ITYPE] = 1'b1;
        w_imm         = w_imm_i;
        w_alu         = w_arith_alu;
        if ((w_f3 == 3'b001) && (w_f7 != 7'b0000000))
          w_bad = 1'b1;
        if ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000))
          w_bad = 1'b1;
      end
      OPC_LOAD: begin
        w_opc[`LOAD] = 1'b1;
        w_imm        = w_imm_i;
        w_alu[`ADD]  = 1'b1;
        if ((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111))
          w_bad = 1'b1;
      end
      OPC_STORE: begin
        w_opc[`STORE] = 1'b1;
        w_imm         = w_imm_s;
        w_alu[`ADD]   = 1'b1;
        if (w_f3 > 3'b010) w_bad = 1'b1;
      end
      OPC_BRANCH: begin
        w_opc[`BRANCH] = 1'b1;
        w_imm          = w_imm_b;
        w_alu          = w_branch_alu;
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) w_bad = 1'b1;
      end
      OPC_JAL: begin
        w_opc[`JAL] = 1'b1;
        w_imm       = w_imm_j;
        w_alu[`ADD] = 1'b1;
      end
      OPC_JALR: begin
        w_opc[`JALR] = 1'b1;
        w_imm        = w_imm_i;
        w_alu[`ADD]  = 1'b1;
        if (w_f3 != 3'b000) w_bad = 1'b1;
      end
      OPC_LUI: begin
        w_opc[`LUI] = 1'b1;
        w_imm       = w_imm_u;
        w_alu[`ADD] = 1'b1;
      end
      OPC_AUIPC: begin
        w_opc[`AUIPC] = 1'b1;
        w_imm         = w_imm_u;
        w_alu[`ADD]   = 1'b1;
      end
      OPC_SYSTEM: begin
        w_opc[`SYSTEM] = 1'b1;
        w_imm          = w_imm_z;
        w_alu[`ADD]    = 1'b1;
      end
      OPC_FENCE: begin
        w_opc[`FENCE] = 1'b1;
        w_imm         = w_imm_z;
        w_alu[`ADD]   = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
    // Illegal encodings present no class or op so execute cannot act on them.
    if (w_bad) begin
      w_opc  = '0;
      w_alu  = '0;
      w_mext = '0;
    end
  end

  // FIFO payload array (no reset: contents are qualified by r_count).
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= i_pc;
      r_mem_inst[r_wr_ptr] <= i_inst;
    end
  end

  // Pointers, occupancy and the output slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_funct3  <= '0;
      r_opcode  <= '0;
      r_alu     <= '0;
      r_mext    <= '0;
      r_illegal <= 1'b0;
    end else if (i_flush) begin
      // Slot data is left as-is; with r_valid low it is don't-care.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_valid   <= 1'b1;
        r_pc      <= w_head_pc;
        r_rs1     <= w_inst[19:15];
        r_rs2     <= w_inst[24:20];
        r_rd      <= w_inst[11:7];
        r_imm     <= w_imm;
        r_funct3  <= w_f3;
        r_opcode  <= w_opc;
        r_alu     <= w_alu;
        r_mext    <= w_mext;
        r_illegal <= w_bad;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_rs1_addr = r_rs1;
  assign o_rs2_addr = r_rs2;
  assign o_rd_addr  = r_rd;
  assign o_imm      = r_imm;
  assign o_funct3   = r_funct3;
  assign o_opcode   = r_opcode;
  assign o_alu_op   = r_alu;
  assign o_mext_op  = r_mext;
  assign o_illegal  = r_illegal;
  assign o_count    = r_count;

endmodule
